// File: rtl/ay8913_seq_pkg.sv
// ---------------------------------------------------------------------------
// ay8913_seq_pkg
// Shared types for the AY-3-8913 bus sequencer:
//   state_e  - sequencer FSM states
//   BUS_*    - {BDIR, BC1} encodings driven onto the tile's uio_in[1:0]
//   cmd_t    - one queued command {addr, data, delay} (28 bits)
// ---------------------------------------------------------------------------
package ay8913_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP_A,
    ST_DATA,
    ST_GAP_D,
    ST_WAIT
  } state_e;

  // {BDIR, BC1}. The read encoding 2'b01 is never produced.
  localparam logic [1:0] BUS_IDLE  = 2'b00;
  localparam logic [1:0] BUS_LATCH = 2'b11;
  localparam logic [1:0] BUS_WRITE = 2'b10;

  typedef struct packed {
    logic [3:0]  addr;   // AY register index
    logic [7:0]  data;   // value to write
    logic [15:0] delay;  // idle clocks after the write
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead read (rdata_o is the current head).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push_i / wdata_i    write strobe and data (ignored while full)
//   pop_i               remove head (ignored while empty)
//   flush_i             empty the FIFO; wins over push and pop
//   rdata_o             head entry
//   full_o, empty_o     status from the registered count
//   count_o             number of stored entries
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // Full is judged on the registered count, so a push and pop in the same
  // clock while full only succeeds for the pop.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ay8913_bus_sequencer.sv
// ---------------------------------------------------------------------------
// ay8913_bus_sequencer
// Replays queued {register, value, post-delay} commands as AY-3-8913 bus
// cycles: address latch, gap, data write, gap, then an optional idle delay.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid / cmd_ready       host push handshake
//   cmd_reg, cmd_data, cmd_wait command fields
//   flush                       synchronous abort of queue and current command
//   busy                        FSM active or commands pending
//   ay_bus, ay_bc1, ay_bdir     registered AY bus outputs
//   done_pulse                  one clock when a command's delay expires
// ---------------------------------------------------------------------------
module ay8913_bus_sequencer
  import ay8913_seq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PHASE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_reg,
  input  logic [7:0]  cmd_data,
  input  logic [15:0] cmd_wait,
  input  logic        flush,
  output logic        busy,
  output logic [7:0]  ay_bus,
  output logic        ay_bc1,
  output logic        ay_bdir,
  output logic        done_pulse
);

  localparam logic [3:0] PH_LAST  = 4'(PHASE_CYC - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  state_e        state_q, state_d;
  cmd_t          cur_q, cur_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   wait_q, wait_d;
  logic [1:0]    ctl_q, ctl_d;
  logic [7:0]    bus_q, bus_d;
  logic          done_q, done_d;

  cmd_t                   fifo_wdata, fifo_head;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  assign fifo_wdata = '{addr: cmd_reg, data: cmd_data, delay: cmd_wait};

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid),
    .pop_i   (fifo_pop),
    .flush_i (flush),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign cmd_ready  = !fifo_full;
  assign busy       = (state_q != ST_IDLE) || (fifo_count != '0);
  assign ay_bdir    = ctl_q[1];
  assign ay_bc1     = ctl_q[0];
  assign ay_bus     = bus_q;
  assign done_pulse = done_q;

  // Next state and next output values are computed together so the bus
  // outputs change on the same edge as the state that owns them.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    ctl_d    = BUS_IDLE;
    bus_d    = bus_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_head;
          state_d  = ST_ADDR;
          cnt_d    = PH_LAST;
          ctl_d    = BUS_LATCH;
          bus_d    = {4'b0, fifo_head.addr};
        end
      end
      ST_ADDR: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP_A;
          cnt_d   = GAP_LAST;
        end else begin
          ctl_d = BUS_LATCH;
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_GAP_A: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = PH_LAST;
          ctl_d   = BUS_WRITE;
          bus_d   = cur_q.data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP_D;
          cnt_d   = GAP_LAST;
        end else begin
          ctl_d = BUS_WRITE;
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_GAP_D: begin
        if (cnt_q == '0) begin
          if (cur_q.delay != '0) begin
            state_d = ST_WAIT;
            wait_d  = cur_q.delay;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_WAIT: begin
        // Counts delay..1, so WAIT occupies exactly 'delay' clocks.
        if (wait_q == 16'd1) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a done pulse due this clock.
    if (flush) begin
      state_d  = ST_IDLE;
      ctl_d    = BUS_IDLE;
      bus_d    = '0;
      done_d   = 1'b0;
      fifo_pop = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      ctl_q   <= BUS_IDLE;
      bus_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      ctl_q   <= ctl_d;
      bus_q   <= bus_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_ay8913_bus_sequencer.sv
module tb_ay8913_bus_sequencer;

  localparam int DEPTH = 8;
  localparam int PH    = 2;
  localparam int GP    = 1;
  localparam int MAXC  = 256;
  localparam int BODY  = 2*PH + 2*GP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_reg = '0;
  logic [7:0]  cmd_data = '0;
  logic [15:0] cmd_wait = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [7:0]  ay_bus;
  logic        ay_bc1, ay_bdir, done_pulse;

  ay8913_bus_sequencer #(.DEPTH(DEPTH), .PHASE_CYC(PH), .GAP_CYC(GP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data), .cmd_wait(cmd_wait), .flush(flush),
    .busy(busy), .ay_bus(ay_bus), .ay_bc1(ay_bc1), .ay_bdir(ay_bdir),
    .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number N, cyc == N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model: scheduled command timeline -------------
  // For each accepted command: push edge p, address-start edge s, done edge d.
  // s = max(p+1, previous d + 1); d = s + 2*PH + 2*GP + wait.
  int         m_p [MAXC];
  int         m_s [MAXC];
  int         m_d [MAXC];
  logic [3:0] m_a [MAXC];
  logic [7:0] m_v [MAXC];
  int         mn = 0;
  int         accepted = 0;

  task automatic model_push(input logic [3:0] a, input logic [7:0] v, input int w, input int p);
    int s;
    s = p + 1;
    if (mn > 0 && m_d[mn-1] + 1 > s) s = m_d[mn-1] + 1;
    if (mn < MAXC) begin
      m_p[mn] = p; m_s[mn] = s; m_d[mn] = s + BODY + w;
      m_a[mn] = a; m_v[mn] = v;
      mn++;
    end
    accepted++;
  endtask

  // Anything not finished strictly before the flush edge is discarded.
  task automatic model_flush(input int f);
    while (mn > 0 && m_d[mn-1] >= f) mn--;
  endtask

  task automatic model_check();
    int t, off, occ;
    logic [1:0] e_ctl;
    logic [7:0] e_bus;
    bit chk_bus, e_done, e_busy;
    t = cyc; occ = 0; e_ctl = 2'b00; e_bus = '0;
    chk_bus = 0; e_done = 0; e_busy = 0;
    for (int k = 0; k < mn; k++) begin
      if (t >= m_s[k] && t <= m_d[k]) begin
        off = t - m_s[k];
        if (off < PH)               begin e_ctl = 2'b11; e_bus = {4'b0, m_a[k]}; chk_bus = 1; end
        else if (off < PH + GP)     begin e_ctl = 2'b00; e_bus = {4'b0, m_a[k]}; chk_bus = 1; end
        else if (off < 2*PH + GP)   begin e_ctl = 2'b10; e_bus = m_v[k];         chk_bus = 1; end
        else if (off < BODY)        begin e_ctl = 2'b00; e_bus = m_v[k];         chk_bus = 1; end
        if (t == m_d[k]) e_done = 1;
      end
      if (m_p[k] <= t && t < m_d[k]) e_busy = 1;
      if (m_p[k] <= t && t < m_s[k]) occ++;
    end
    check("bdir_bc1", {ay_bdir, ay_bc1}, e_ctl);
    check("done_pulse", done_pulse, e_done);
    check("busy", busy, e_busy);
    check("cmd_ready", cmd_ready, (occ < DEPTH));
    if (chk_bus) check("ay_bus", ay_bus, e_bus);
  endtask

  // ---------------- observation of address-phase starts ----------------------
  int         starts[$];
  logic [3:0] addrs[$];
  logic [1:0] prev_ctl = 2'b00;
  int         done_count = 0;
  int         last_done = 0;

  // Called at a negedge: drive inputs for the next posedge, then sample.
  task automatic step(input bit v, input logic [3:0] a, input logic [7:0] d,
                      input logic [15:0] w, input bit fl);
    cmd_valid = v; cmd_reg = a; cmd_data = d; cmd_wait = w; flush = fl;
    if (fl) model_flush(cyc + 1);
    else if (v && cmd_ready) model_push(a, d, int'(w), cyc + 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; flush = 1'b0;
    model_check();
    if ({ay_bdir, ay_bc1} == 2'b11 && prev_ctl != 2'b11) begin
      starts.push_back(cyc);
      addrs.push_back(ay_bus[3:0]);
    end
    prev_ctl = {ay_bdir, ay_bc1};
    if (done_pulse) begin done_count++; last_done = cyc; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0);
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    step(0, '0, '0, '0, 0);
    while (busy && k < bound) begin
      step(0, '0, '0, '0, 0);
      k++;
    end
    check("drain_idle", busy, 1'b0);
    idle(2);
  endtask

  typedef struct {
    bit         v;
    logic [3:0] a;
    logic [7:0] d;
    logic [15:0] w;
    logic [1:0] ctl;
    logic [7:0] bus;
    bit         done;
    bit         bsy;
    bit         cb;   // compare ay_bus on this row
    bit         cy;   // compare busy on this row
  } vec_t;

  vec_t vecs[9];

  initial begin
    int target, idx, k, d0, p5;

    // Single write, one row per clock after the push edge.
    vecs[0] = '{1, 4'h7, 8'h38, 16'd0, 2'b00, 8'h00, 0, 1, 1, 1};
    vecs[1] = '{0, 4'h0, 8'h00, 16'd0, 2'b11, 8'h07, 0, 1, 1, 1};
    vecs[2] = '{0, 4'h0, 8'h00, 16'd0, 2'b11, 8'h07, 0, 1, 1, 1};
    vecs[3] = '{0, 4'h0, 8'h00, 16'd0, 2'b00, 8'h07, 0, 1, 1, 1};
    vecs[4] = '{0, 4'h0, 8'h00, 16'd0, 2'b10, 8'h38, 0, 1, 1, 1};
    vecs[5] = '{0, 4'h0, 8'h00, 16'd0, 2'b10, 8'h38, 0, 1, 1, 1};
    vecs[6] = '{0, 4'h0, 8'h00, 16'd0, 2'b00, 8'h38, 0, 1, 1, 1};
    vecs[7] = '{0, 4'h0, 8'h00, 16'd0, 2'b00, 8'h00, 1, 0, 0, 0};
    vecs[8] = '{0, 4'h0, 8'h00, 16'd0, 2'b00, 8'h00, 0, 0, 0, 1};

    // ---- reset ----
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bdir_bc1", {ay_bdir, ay_bc1}, 2'b00);
    check("rst_bus", ay_bus, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done_pulse, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    rst_n = 1'b1;
    idle(2);

    // ---- test 1: table-driven single write ----
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].w, 0);
      check("t1_ctl", {ay_bdir, ay_bc1}, vecs[i].ctl);
      check("t1_done", done_pulse, vecs[i].done);
      if (vecs[i].cb) check("t1_bus", ay_bus, vecs[i].bus);
      if (vecs[i].cy) check("t1_busy", busy, vecs[i].bsy);
    end
    idle(2);

    // ---- test 2: three back-to-back commands, wait=10 ----
    starts.delete(); addrs.delete(); d0 = done_count;
    for (int i = 0; i < 3; i++) step(1, 4'(i), 8'(8'h10 + i), 16'd10, 0);
    drain(200);
    check("t2_starts", starts.size(), 3);
    check("t2_dones", done_count - d0, 3);
    if (starts.size() == 3) begin
      for (int i = 0; i < 3; i++) check("t2_addr_order", addrs[i], 4'(i));
      check("t2_spacing01", starts[1] - starts[0], BODY + 10 + 1);
      check("t2_spacing12", starts[2] - starts[1], BODY + 10 + 1);
    end

    // ---- test 3: fill FIFO behind a long wait ----
    step(1, 4'hF, 8'hAA, 16'd1000, 0);
    idle(3);
    accepted = 0;
    for (int i = 0; i <= DEPTH; i++) step(1, 4'(i), 8'(8'h80 + i), 16'd0, 0);
    check("t3_accepted", accepted, DEPTH);
    check("t3_ready_full", cmd_ready, 1'b0);
    starts.delete();
    drain(3000);
    check("t3_writes", starts.size(), DEPTH);

    // ---- test 4: flush during DATA of command 2 of 4 ----
    for (int i = 0; i < 4; i++) step(1, 4'(i + 4), 8'(8'h40 + i), 16'd0, 0);
    idx = mn - 3;
    target = m_s[idx] + PH + GP;
    k = 0;
    while (cyc != target && k < 100) begin step(0, '0, '0, '0, 0); k++; end
    check("t4_in_data", {ay_bdir, ay_bc1}, 2'b10);
    d0 = done_count;
    step(1, 4'hE, 8'hEE, 16'd0, 1);   // push alongside flush must be dropped
    check("t4_flush_bdir", ay_bdir, 1'b0);
    check("t4_flush_bus", ay_bus, 8'h00);
    starts.delete();
    idle(40);
    check("t4_no_done", done_count - d0, 0);
    check("t4_no_more_writes", starts.size(), 0);
    check("t4_busy", busy, 1'b0);

    // ---- random traffic against the model ----
    for (int i = 0; i < 120; i++) begin
      step(($urandom_range(0, 2) == 0), 4'($urandom), 8'($urandom),
           16'($urandom_range(0, 6)), ($urandom_range(0, 59) == 0));
    end
    drain(2000);

    // ---- test 5: asynchronous reset mid-WAIT ----
    step(1, 4'h5, 8'h5A, 16'd20, 0);
    target = m_s[mn-1] + BODY + 5;
    k = 0;
    while (cyc != target && k < 100) begin step(0, '0, '0, '0, 0); k++; end
    check("t5_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_bdir_bc1", {ay_bdir, ay_bc1}, 2'b00);
    check("t5_rst_bus", ay_bus, 8'h00);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_done", done_pulse, 1'b0);
    check("t5_rst_ready", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mn = 0; prev_ctl = 2'b00;
    idle(2);
    starts.delete();
    p5 = cyc + 1;
    step(1, 4'h9, 8'h99, 16'd0, 0);
    drain(100);
    check("t5_restart_count", starts.size(), 1);
    if (starts.size() == 1) check("t5_restart_time", starts[0], p5 + 1);

    // ---- test 6: maximum wait ----
    starts.delete(); d0 = done_count;
    step(1, 4'h3, 8'hC3, 16'hFFFF, 0);
    drain(70000);
    check("t6_dones", done_count - d0, 1);
    check("t6_starts", starts.size(), 1);
    if (starts.size() == 1) check("t6_wait_len", last_done - (starts[0] + BODY), 65535);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
